decoder: RTL and testbench
==========================

# decoder

Decode/issue stage directly upstream of the RV64 ALU. Accepts 32-bit instructions from fetch over a valid/ready handshake, buffers them in a 2-entry FIFO, and slices them into the ALU's `regA`/`regB`/`opcode`/`regDest` fields. A 32-entry busy-register scoreboard holds back any instruction whose source registers are still awaiting writeback.

## Interface
- `PC_W`, default 64: width of the program-counter side-band.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  decoder can accept an instruction this cycle.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  PC_W  address of `in_instr`.
- `out_valid`  out  1  decoded instruction is issuable.
- `out_ready`  in  1  downstream consumes it this cycle.
- `regA`  out  5  instr[19:15].
- `regB`  out  12  immediate or {funct7, rs2}; see Operation.
- `opcode`  out  10  {instr[14:12], instr[6:0]}.
- `regDest`  out  5  destination register, or rs2 for store/branch.
- `out_pc`  out  PC_W  PC of the head instruction.
- `out_illegal`  out  1  head major opcode is unsupported.
- `wb_valid`  in  1  a register write retires this cycle.
- `wb_reg`  in  5  register being written.

## Operation
**FIFO**
- 2 entries; each stores {instr, pc}.
- Push on `in_valid && in_ready`. Pop on `out_valid && out_ready`.
- `in_ready` = (count != 2) && !reset.
- Push and pop in the same cycle leave count unchanged.
- Output fields are decoded combinationally from the head entry.

**Legal major opcodes (instr[6:0])**
- 0x13, 0x1b, 0x33, 0x3b, 0x03, 0x23, 0x63, 0x37, 0x17, 0x6f, 0x67, 0x73, 0x0f.
- Any other value sets `out_illegal` = 1.

**regB / regDest slicing**
- Default (I, R, U, J types): `regB` = instr[31:20], `regDest` = instr[11:7].
  - For R-type this yields {funct7, rs2}.
  - For U/J types, {`regB`, `regA`, instr[14:12]} reproduces instr[31:12].
- Store (0x23) and branch (0x63): `regB` = {instr[31:25], instr[11:7]}, `regDest` = instr[24:20].

**Sources checked for hazards**
- rs1 (instr[19:15]) for every legal opcode except 0x37, 0x17, 0x6f.
- rs2 (instr[24:20]) additionally for 0x33, 0x3b, 0x23, 0x63.

**Scoreboard**
- 32-bit `busy` vector; bit 0 is hardwired to 0.
- hazard = any checked source has its `busy` bit set.
- `out_valid` = (count != 0) && !hazard.
- Illegal instructions skip the hazard check and never set `busy`.
- On issue, `busy[regDest]` is set when all of the following hold:
  - the instruction is legal;
  - its opcode is not 0x23, 0x63 or 0x0f;
  - `regDest` != 0.
- `wb_valid` clears `busy[wb_reg]`.
- Set and clear of the same register in the same cycle: set wins.
- No writeback bypass: a cleared bit affects `hazard` starting the cycle after `wb_valid`.

## Timing
**Reset values**
- count = 0, `busy` = 0, head entry = 0.
- Outputs: `out_valid` = 0, `out_illegal` = 0, `regA`/`regB`/`regDest` = 0, `out_pc` = 0, `opcode` = 0; `in_ready` = 0 while `reset` is high.
- Reset asserted mid-operation discards all buffered instructions and busy bits asynchronously.
- First cycle after reset release: `in_ready` = 1.

**Latency and throughput**
- An instruction pushed at edge N appears on the outputs in the cycle after N (1-cycle latency).
- With `out_ready` held high and no hazards, throughput is 1 instruction/cycle.

**Handshake rules**
- While `out_valid` is high and `out_ready` is low, all outputs hold stable.
- `out_valid` may drop only through a pop or a hazard; it may rise when a hazard clears.
- A hazard stalls only the head instruction; fetch can still fill the second FIFO entry.
- FIFO full (count 2): `in_ready` = 0. A pop that cycle raises `in_ready` the next cycle.
- FIFO empty: `out_valid` = 0, and a push is visible the next cycle (no fall-through).

## Test plan
- **Field slicing:** reset, push `addi x5,x6,-1` (0xfff30293) -> next cycle `out_valid`=1, `opcode`=0x013, `regA`=6, `regB`=0xfff, `regDest`=5; `out_ready`=1 -> `busy[5]` set.
- **RAW stall:** push `addi x5,x6,1` then `add x7,x5,x8`.
  - Second instruction -> `out_valid`=0 while `busy[5]` is set.
  - `wb_valid`=1, `wb_reg`=5 at edge M -> `out_valid`=1 in the cycle after M, with `opcode`=0x033 and `regB`={7'h00,5'd8}.
- **Full/backpressure:** `out_ready`=0, push 3 back-to-back -> `in_ready`=0 after the 2nd accept and the 3rd is held; head outputs stable; release `out_ready` -> all 3 issue in order with matching `out_pc`.
- **Store slicing / no busy:** `sd x9,16(x2)` (0x00913823) -> `opcode`=0x1a3, `regB`=0x010, `regDest`=9; `busy` unchanged after issue.
- **Illegal and simultaneous events:**
  - Opcode 0x7f -> `out_illegal`=1, `out_valid`=1, no busy set.
  - Same-cycle issue of `addi x3` and `wb_reg`=3 -> `busy[3]` remains set.
- **Async reset:** assert `reset` mid-stall -> `out_valid`, `in_ready` and all `busy` bits go to 0 immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/decoder.sv
// Decode/issue stage feeding the RV64 ALU: a 2-entry instruction FIFO, field slicing
// of the head entry, and a busy-register scoreboard that holds back RAW hazards.
module decoder #(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      regA,
    output logic [11:0]     regB,
    output logic [9:0]      opcode,
    output logic [4:0]      regDest,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_reg
);

    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_IMM32 = 7'h1b;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_REG32 = 7'h3b;
    localparam logic [6:0] LOAD     = 7'h03;
    localparam logic [6:0] STORE    = 7'h23;
    localparam logic [6:0] BRANCH   = 7'h63;
    localparam logic [6:0] LUI      = 7'h37;
    localparam logic [6:0] AUIPC    = 7'h17;
    localparam logic [6:0] JAL      = 7'h6f;
    localparam logic [6:0] JALR     = 7'h67;
    localparam logic [6:0] SYSTEM   = 7'h73;
    localparam logic [6:0] MISC_MEM = 7'h0f;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_IMM, OP_IMM32, OP_REG, OP_REG32, LOAD, STORE, BRANCH,
            LUI, AUIPC, JAL, JALR, SYSTEM, MISC_MEM: is_legal = 1'b1;
            default:                                 is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        uses_rs1 = is_legal(op) && (op != LUI) && (op != AUIPC) && (op != JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        uses_rs2 = (op == OP_REG) || (op == OP_REG32) || (op == STORE) || (op == BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        writes_rd = is_legal(op) && (op != STORE) && (op != BRANCH) && (op != MISC_MEM);
    endfunction

    logic [31:0]     instr_q [2];
    logic [PC_W-1:0] pc_q    [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    logic [31:0]     head;
    logic [6:0]      major;
    logic            legal;
    logic            not_empty;
    logic            hazard;
    logic            push;
    logic            pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // FIFO storage and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= in_instr;
                pc_q[wr_ptr]    <= in_pc;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head decode
    always_comb begin
        head      = instr_q[rd_ptr];
        major     = head[6:0];
        legal     = is_legal(major);
        not_empty = (count != 2'd0);
        regA      = head[19:15];
        opcode    = {head[14:12], major};
        out_pc    = pc_q[rd_ptr];
        if ((major == STORE) || (major == BRANCH)) begin
            regB    = {head[31:25], head[11:7]};
            regDest = head[24:20];
        end else begin
            regB    = head[31:20];
            regDest = head[11:7];
        end
        // Illegal heads bypass the scoreboard so they can drain to the trap path.
        hazard = legal && ((uses_rs1(major) && busy[head[19:15]]) ||
                           (uses_rs2(major) && busy[head[24:20]]));
        out_valid   = not_empty && !hazard;
        out_illegal = not_empty && !legal;
        in_ready    = (count != 2'd2) && !reset;
    end

    // Scoreboard: a set on issue overrides a same-cycle writeback clear.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_reg] = 1'b0;
        end
        if (pop && writes_rd(major) && (regDest != 5'd0)) begin
            busy_nxt[regDest] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes expected decodes into a queue and a
// negedge monitor pops and compares each issued instruction.
module tb_decoder;

    localparam int PC_W = 64;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      regA;
    logic [11:0]     regB;
    logic [9:0]      opcode;
    logic [4:0]      regDest;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;
    logic            wb_valid;
    logic [4:0]      wb_reg;

    decoder #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .regA(regA), .regB(regB), .opcode(opcode), .regDest(regDest),
        .out_pc(out_pc), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_reg(wb_reg)
    );

    typedef struct {
        logic [9:0]  opc;
        logic [4:0]  ra;
        logic [11:0] rb;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [9:0] opc, input logic [4:0] ra,
                                input logic [11:0] rb, input logic [4:0] rd,
                                input logic [63:0] pc, input logic ill);
        exp_t e;
        e.opc = opc; e.ra = ra; e.rb = rb; e.rd = rd; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Offer one instruction until accepted; optionally record its expected decode.
    task automatic send(input logic [31:0] ins, input logic [63:0] pc, input exp_t e,
                        input bit track);
        bit ok;
        bit rdy;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: instr %0h not accepted, required acceptance", ins);
        end else if (track) begin
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        out_ready = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d pending, required 0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got pc %0h, required no issue", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("opcode",  {54'd0, opcode},  {54'd0, mon_e.opc});
                chk("regA",    {59'd0, regA},    {59'd0, mon_e.ra});
                chk("regB",    {52'd0, regB},    {52'd0, mon_e.rb});
                chk("regDest", {59'd0, regDest}, {59'd0, mon_e.rd});
                chk("out_pc",  out_pc,           mon_e.pc);
                chk("illegal", {63'd0, out_illegal}, {63'd0, mon_e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_reg = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_illegal",   {63'd0, out_illegal}, 64'd0);
        chk("rst_fields",    {27'd0, regA, regB, opcode, regDest}, 64'd0);
        chk("rst_out_pc",    out_pc, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Field slicing: addi x5,x6,-1
        send(32'hfff30293, 64'h1000, mk(10'h013, 5'd6, 12'hfff, 5'd5, 64'h1000, 1'b0), 1'b1);
        @(negedge clk);
        chk("addi_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        drain();
        chk("busy_after_addi", dut.busy, 64'h20);

        wb_valid = 1'b1; wb_reg = 5'd5;
        @(posedge clk); #1 wb_valid = 1'b0;
        chk("busy_after_wb5", dut.busy, 64'h0);

        // RAW stall: addi x5,x6,1 then add x7,x5,x8
        out_ready = 1'b1;
        send(32'h00130293, 64'h1100, mk(10'h013, 5'd6, 12'h001, 5'd5, 64'h1100, 1'b0), 1'b1);
        send(32'h008283b3, 64'h1104, mk(10'h033, 5'd5, 12'h008, 5'd7, 64'h1104, 1'b0), 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk); #1 wb_valid = 1'b1; wb_reg = 5'd5;
        @(negedge clk);
        chk("raw_stall_wb_cycle", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1 wb_valid = 1'b0;
        @(negedge clk);
        chk("raw_release", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        drain();

        // Full FIFO and backpressure
        send(32'h00100513, 64'h2000, mk(10'h013, 5'd0, 12'h001, 5'd10, 64'h2000, 1'b0), 1'b1);
        send(32'h00200593, 64'h2004, mk(10'h013, 5'd0, 12'h002, 5'd11, 64'h2004, 1'b0), 1'b1);
        fork
            send(32'h00300613, 64'h2008, mk(10'h013, 5'd0, 12'h003, 5'd12, 64'h2008, 1'b0), 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_in_ready",  {63'd0, in_ready},  64'd0);
                    chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
                    chk("hold_out_pc",    out_pc,             64'h2000);
                    chk("hold_regB",      {52'd0, regB},      64'h001);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("busy_before_store", dut.busy, 64'h1c80);

        // Store slicing, no busy update: sd x9,16(x2)
        send(32'h00913823, 64'h3000, mk(10'h1a3, 5'd2, 12'h010, 5'd9, 64'h3000, 1'b0), 1'b1);
        drain();
        chk("busy_after_store", dut.busy, 64'h1c80);

        // Illegal opcode 0x7f reading busy x7: issues anyway, sets nothing
        send(32'h000382ff, 64'h3100, mk(10'h07f, 5'd7, 12'h000, 5'd5, 64'h3100, 1'b1), 1'b1);
        @(negedge clk);
        chk("illegal_out_valid", {63'd0, out_valid}, 64'd1);
        chk("illegal_flag",      {63'd0, out_illegal}, 64'd1);
        @(posedge clk); #1;
        drain();
        chk("busy_after_illegal", dut.busy, 64'h1c80);

        // Same-cycle issue of addi x3 and writeback of x3: set wins
        out_ready = 1'b1;
        send(32'h00000193, 64'h3200, mk(10'h013, 5'd0, 12'h000, 5'd3, 64'h3200, 1'b0), 1'b1);
        wb_valid = 1'b1; wb_reg = 5'd3;
        @(posedge clk); #1 wb_valid = 1'b0;
        out_ready = 1'b0;
        chk("busy_set_wins", dut.busy, 64'h1c88);

        // Async reset mid-stall: add x13,x10,x0 waits on busy x10
        out_ready = 1'b1;
        send(32'h000506b3, 64'h4000, mk(10'h033, 5'd10, 12'h000, 5'd13, 64'h4000, 1'b0), 1'b0);
        @(negedge clk);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd0);
        chk("stall_in_ready",  {63'd0, in_ready},  64'd1);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_in_ready",  {63'd0, in_ready},  64'd0);
        chk("async_busy",      dut.busy,           64'd0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rerst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rerst_in_ready",  {63'd0, in_ready},  64'd1);
        @(posedge clk); #1;
        send(32'h000506b3, 64'h4100, mk(10'h033, 5'd10, 12'h000, 5'd13, 64'h4100, 1'b0), 1'b1);
        drain();

        chk("queue_empty", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
